// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the F/D/E/W pipeline: register update codes, PC control,
// multi-cycle execute wait, load-use interlock, redirect, halt and a stall counter.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ext_stall,
    input  logic [5:0]       d_rs,
    input  logic             d_use_rs,
    input  logic [5:0]       d_rt,
    input  logic             d_use_rt,
    input  logic [1:0]       de_rw,
    input  logic [4:0]       de_rd,
    input  logic             de_is_load,
    input  logic [4:0]       de_wait_time,
    input  logic             de_stop,
    input  logic             e_redirect,
    output logic [1:0]       fd_update,
    output logic [1:0]       de_update,
    output logic [1:0]       ew_update,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [1:0] UPD_HOLD  = 2'b00;
    localparam logic [1:0] UPD_ADV   = 2'b01;
    localparam logic [1:0] UPD_FLUSH = 2'b10;

    logic [1:0] state, state_nx;
    logic [4:0] cnt, cnt_nx;
    logic       rs_hit, rt_hit, hz;

    // File select and index must both match; register 0 is a real register here.
    assign rs_hit = d_use_rs && (de_rw[1] == d_rs[5]) && (de_rd == d_rs[4:0]);
    assign rt_hit = d_use_rt && (de_rw[1] == d_rt[5]) && (de_rd == d_rt[4:0]);
    assign hz     = de_is_load && (de_rw != 2'b00) && (rs_hit || rt_hit);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves a latch.
        fd_update = UPD_HOLD;
        de_update = UPD_HOLD;
        ew_update = UPD_HOLD;
        pc_en     = 1'b0;
        pc_sel    = 1'b0;
        halted    = 1'b0;
        state_nx  = state;
        cnt_nx    = cnt;

        if (!rstn) begin
            // Pipeline is held idle for the whole reset cycle.
        end else if (state == ST_HALT) begin
            fd_update = UPD_FLUSH;
            de_update = UPD_FLUSH;
            ew_update = UPD_FLUSH;
            halted    = 1'b1;
        end else if (ext_stall) begin
            // Freeze everything, including the wait countdown.
        end else if (state == ST_RUN && de_wait_time != 5'd0) begin
            ew_update = UPD_FLUSH;
            cnt_nx    = de_wait_time - 5'd1;
            state_nx  = ST_WAIT;
        end else if (state == ST_WAIT && cnt != 5'd0) begin
            ew_update = UPD_FLUSH;
            cnt_nx    = cnt - 5'd1;
        end else begin
            // E instruction completes this cycle; a finished wait never re-enters WAIT.
            state_nx = ST_RUN;
            if (de_stop) begin
                fd_update = UPD_FLUSH;
                de_update = UPD_FLUSH;
                ew_update = UPD_ADV;
                state_nx  = ST_HALT;
            end else if (e_redirect) begin
                fd_update = UPD_FLUSH;
                de_update = UPD_FLUSH;
                ew_update = UPD_ADV;
                pc_en     = 1'b1;
                pc_sel    = 1'b1;
            end else if (hz) begin
                de_update = UPD_FLUSH;
                ew_update = UPD_ADV;
            end else begin
                fd_update = UPD_ADV;
                de_update = UPD_ADV;
                ew_update = UPD_ADV;
                pc_en     = 1'b1;
            end
        end
    end

    // NOTE: reset is sampled on the clock edge (synchronous), so it sits inside the edge branch.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_RUN;
            cnt         <= 5'd0;
            stall_count <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state != ST_HALT && !pc_en && stall_count != {CNT_W{1'b1}})
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule
